// File: rtl/cam_capture_pack.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture_pack
// Purpose  : Camera (DVP-style) capture front end. Frames incoming bytes on
//            vsync/href, assembles multi-byte pixels, drops pixels for
//            horizontal decimation, packs kept bytes into wide words and
//            queues them in a first-word-fall-through FIFO with sof/eol tags.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            enable              - arm capture (looked at in IDLE/WAIT_FRAME)
//            cam_dat/href/vsync  - IO-registered camera inputs
//            m_data/m_sof/m_eol  - FIFO head word and its tags
//            m_valid/m_ready     - output stream handshake
//            overflow            - sticky word-dropped flag, clr_overflow clears
//            frame_count         - completed frames (wraps)
//            line_count          - lines seen in the current frame
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_pack #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned BYTES_PER_PIXEL   = 2,
  parameter int unsigned WORD_BYTES        = 4,
  parameter int unsigned SUBSAMPLE         = 1,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [DATA_WIDTH-1:0]            cam_dat,
  input  logic                             cam_href,
  input  logic                             cam_vsync,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] m_data,
  output logic                             m_sof,
  output logic                             m_eol,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             overflow,
  input  logic                             clr_overflow,
  output logic [15:0]                      frame_count,
  output logic [15:0]                      line_count
);

  localparam int unsigned WORD_W  = DATA_WIDTH * WORD_BYTES;
  localparam int unsigned ENTRY_W = WORD_W + 2;
  localparam int unsigned CNT_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned BIDX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  localparam logic [15:0]       C_SUB_MASK      = 16'(SUBSAMPLE - 1);
  localparam logic [CNT_W-1:0]  C_LAST_WORD_B   = CNT_W'(WORD_BYTES - 1);
  localparam logic [BIDX_W-1:0] C_LAST_PIX_B    = BIDX_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } state_t;

  // Input stage plus one cycle of history for edge detection
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  href_q, vsync_q, href_prev_q, vsync_prev_q;

  state_t                state_q, state_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [15:0]           column_q, column_d;
  logic [WORD_W-1:0]     pack_q, pack_d;
  logic [CNT_W-1:0]      pack_cnt_q, pack_cnt_d;
  logic [WORD_W-1:0]     stage_q, stage_d;
  logic                  stage_v_q, stage_v_d;
  logic                  sof_pending_q, sof_pending_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [15:0]           line_count_q, line_count_d;

  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic                  blank_cur, blank_prev, blank_exit, blank_entry;
  logic                  href_rise, href_fall, line_end;
  logic                  push, push_eol, fifo_we, fifo_full, fifo_empty, pop;
  logic [WORD_W-1:0]     push_word, pack_tmp;
  logic [BIDX_W-1:0]     cur_idx;
  logic [15:0]           cur_col;
  logic                  keep;
  logic [ENTRY_W-1:0]    head;

  assign blank_cur   = (VSYNC_ACTIVE_HIGH != 0) ? vsync_q      : ~vsync_q;
  assign blank_prev  = (VSYNC_ACTIVE_HIGH != 0) ? vsync_prev_q : ~vsync_prev_q;
  assign blank_exit  = blank_prev & ~blank_cur;
  assign blank_entry = ~blank_prev & blank_cur;
  assign href_rise   = href_q & ~href_prev_q;
  assign href_fall   = ~href_q & href_prev_q;
  // A frame ending mid-line closes that line in the same cycle
  assign line_end    = href_fall | (blank_entry & href_q);

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop         = ~fifo_empty & m_ready;
  assign head        = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    column_d      = column_q;
    pack_d        = pack_q;
    pack_cnt_d    = pack_cnt_q;
    stage_d       = stage_q;
    stage_v_d     = stage_v_q;
    sof_pending_d = sof_pending_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    line_count_d  = line_count_q;
    push          = 1'b0;
    push_eol      = 1'b0;
    push_word     = '0;
    pack_tmp      = pack_q;
    cur_idx       = href_rise ? '0 : byte_idx_q;
    cur_col       = href_rise ? 16'd0 : column_q;
    keep          = ((cur_col & C_SUB_MASK) == 16'd0);

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (blank_exit) begin
          state_d       = ST_ACTIVE;
          line_count_d  = 16'd0;
          sof_pending_d = 1'b1;
          byte_idx_d    = '0;
          column_d      = 16'd0;
          pack_d        = '0;
          pack_cnt_d    = '0;
          stage_v_d     = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (line_end) begin
          // Staging and a partial pack buffer are never both occupied
          if (stage_v_q) begin
            push      = 1'b1;
            push_eol  = 1'b1;
            push_word = stage_q;
            stage_v_d = 1'b0;
          end else if (pack_cnt_q != '0) begin
            push       = 1'b1;
            push_eol   = 1'b1;
            push_word  = pack_q;   // upper bytes are still zero
            pack_d     = '0;
            pack_cnt_d = '0;
          end
          line_count_d = line_count_q + 16'd1;
        end else if (href_q) begin
          if (cur_idx == C_LAST_PIX_B) begin
            byte_idx_d = '0;
            column_d   = cur_col + 16'd1;
          end else begin
            byte_idx_d = cur_idx + BIDX_W'(1);
            column_d   = cur_col;
          end
          if (keep) begin
            // A further kept byte proves the staged word is not end-of-line
            if (stage_v_q) begin
              push      = 1'b1;
              push_word = stage_q;
              stage_v_d = 1'b0;
            end
            pack_tmp[int'(pack_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = dat_q;
            if (pack_cnt_q == C_LAST_WORD_B) begin
              stage_d    = pack_tmp;
              stage_v_d  = 1'b1;
              pack_d     = '0;
              pack_cnt_d = '0;
            end else begin
              pack_d     = pack_tmp;
              pack_cnt_d = pack_cnt_q + CNT_W'(1);
            end
          end
        end
        if (blank_entry) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = enable ? ST_WAIT_FRAME : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Full is judged before this cycle's pop; a dropped sof word leaves
    // sof_pending set so the next accepted word carries it.
    fifo_we = push & ~fifo_full;
    if (fifo_we) sof_pending_d = 1'b0;
    if (clr_overflow) overflow_d = 1'b0;
    if (push & fifo_full) overflow_d = 1'b1;
    wr_ptr_d = wr_ptr_q + (AW+1)'(fifo_we);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dat_q         <= '0;
      href_q        <= 1'b0;
      vsync_q       <= 1'b0;
      href_prev_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      state_q       <= ST_IDLE;
      byte_idx_q    <= '0;
      column_q      <= 16'd0;
      pack_q        <= '0;
      pack_cnt_q    <= '0;
      stage_q       <= '0;
      stage_v_q     <= 1'b0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= 16'd0;
      line_count_q  <= 16'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      dat_q         <= cam_dat;
      href_q        <= cam_href;
      vsync_q       <= cam_vsync;
      href_prev_q   <= href_q;
      vsync_prev_q  <= vsync_q;
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      column_q      <= column_d;
      pack_q        <= pack_d;
      pack_cnt_q    <= pack_cnt_d;
      stage_q       <= stage_d;
      stage_v_q     <= stage_v_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      line_count_q  <= line_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (fifo_we) mem_q[wr_ptr_q[AW-1:0]] <= {sof_pending_q, push_eol, push_word};
    end
  end

  assign m_valid     = ~fifo_empty;
  assign m_data      = m_valid ? head[WORD_W-1:0] : '0;
  assign m_eol       = m_valid & head[WORD_W];
  assign m_sof       = m_valid & head[WORD_W+1];
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  assign line_count  = line_count_q;

endmodule
`default_nettype wire
